// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: controller state
// encodings, the transmitter idle code and the bit-time constant.
// RISCV_SIM_ONLY shortens the bit time for simulation builds.
package uart_pkg;

  typedef logic [1:0] ctrl_state_t;

  localparam ctrl_state_t S_IDLE      = 2'd0;
  localparam ctrl_state_t S_LOAD      = 2'd1;
  localparam ctrl_state_t S_SEND      = 2'd2;
  localparam ctrl_state_t S_WAIT_DONE = 2'd3;

  localparam logic [2:0] UART_TX_IDLE = 3'd0;

`ifdef RISCV_SIM_ONLY
  localparam int UART_BIT_TIME = 10;
`else
  localparam int UART_BIT_TIME = 5210;
`endif

endpackage

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with an occupancy counter as the single source of
// full/empty. A write while full is accepted only if a read happens in
// the same cycle, so a full FIFO can stream without losing a slot.
module sync_fifo_param
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              wr_accept_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push, pop;

  assign full_o      = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign rd_data_o   = mem_q[rd_ptr_q];
  assign pop         = rd_i && !empty_o;
  assign push        = wr_i && (!full_o || pop);
  assign wr_accept_o = push;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards anything queued
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte queue in front of the UART transmitter. Bytes written by the bus
// decoder are buffered, then handed over one at a time: load the head,
// raise tx_send_o until the transmitter leaves idle, then wait for it to
// return to idle before the next byte.
// UART_TX_FIFO_TIMEOUT_EN adds a watchdog on the send handshake that
// drops the byte and sets timeout_o if the transmitter never responds.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
`ifdef UART_TX_FIFO_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            clr_err,
  input  logic [2:0]      tx_state_i,
  output logic            tx_send_o,
  output logic [7:0]      tx_data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [ADDR_W:0] count_o,
  output logic            busy_o,
  output logic            overflow_o,
  output logic            timeout_o
);

  ctrl_state_t state_q, state_d;
  logic        tx_send_q, tx_send_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        overflow_q, overflow_d;
  logic        fifo_pop;
  logic        fifo_accept;
  logic [7:0]  fifo_head;
  logic        tx_idle;

  assign tx_idle = (tx_state_i == UART_TX_IDLE);

  sync_fifo_param #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .wr_i        (wr_en),
    .wr_data_i   (wr_data),
    .rd_i        (fifo_pop),
    .rd_data_o   (fifo_head),
    .wr_accept_o (fifo_accept),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .count_o     (count_o)
  );

`ifdef UART_TX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic          timeout_evt;
`endif

  // Controller sequencing, output register next-state and sticky flags
  always_comb begin
    state_d    = state_q;
    tx_send_d  = tx_send_q;
    tx_data_d  = tx_data_q;
    fifo_pop   = 1'b0;
`ifdef UART_TX_FIFO_TIMEOUT_EN
    timer_d     = timer_q;
    timeout_evt = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty_o && tx_idle) state_d = S_LOAD;
      end
      S_LOAD: begin
        fifo_pop  = 1'b1;
        tx_data_d = fifo_head;
        tx_send_d = 1'b1;
        state_d   = S_SEND;
`ifdef UART_TX_FIFO_TIMEOUT_EN
        timer_d   = '0;
`endif
      end
      S_SEND: begin
        if (!tx_idle) begin
          tx_send_d = 1'b0;
          state_d   = S_WAIT_DONE;
        end
`ifdef UART_TX_FIFO_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          tx_send_d   = 1'b0;
          state_d     = S_IDLE;
          timeout_evt = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      S_WAIT_DONE: begin
        if (tx_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    overflow_d = overflow_q;
    if (clr_err) overflow_d = 1'b0;
    else if (wr_en && !fifo_accept) overflow_d = 1'b1;
`ifdef UART_TX_FIFO_TIMEOUT_EN
    timeout_d = timeout_q;
    if (clr_err) timeout_d = 1'b0;
    else if (timeout_evt) timeout_d = 1'b1;
`endif
  end

  // Controller state and registered outputs; reset aborts any frame
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef UART_TX_FIFO_TIMEOUT_EN
  // Handshake watchdog registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign tx_send_o  = tx_send_q;
  assign tx_data_o  = tx_data_q;
  assign overflow_o = overflow_q;
  assign busy_o     = (state_q != S_IDLE) || !empty_o;

endmodule
